// File: rtl/stack_controller.sv
// Operand-stack controller: owns the stack pointer and DEPTH x 8 storage, sequences PUSH/POP/POP2/CLEAR.
// Optional PEEK (op 100) is built only when STACK_PEEK_EN is defined; otherwise op 100 is illegal.
module stack_controller #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd_op,
  input  logic [7:0]    cmd_data,
  output logic          cmd_ready,
  output logic          rsp_valid,
  output logic          rsp_error,
  output logic [7:0]    rsp_a,
  output logic [7:0]    rsp_b,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          ovf_sticky,
  output logic          unf_sticky
);

  localparam logic [2:0] OP_PUSH  = 3'b000;
  localparam logic [2:0] OP_POP   = 3'b001;
  localparam logic [2:0] OP_POP2  = 3'b010;
  localparam logic [2:0] OP_CLEAR = 3'b011;
`ifdef STACK_PEEK_EN
  localparam logic [2:0] OP_PEEK  = 3'b100;
`endif

  localparam logic [AW:0] ONE       = (AW+1)'(1);
  localparam logic [AW:0] TWO       = (AW+1)'(2);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_A, RD_B, RESP} state_t;

  state_t      state;
  logic [7:0]  mem [DEPTH];
  logic [7:0]  rd_data;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic        err_q;
  logic        pop2_q;
`ifdef STACK_PEEK_EN
  logic        peek_q;
`endif
  logic [AW:0] rd_ptr;
  logic        wr_en;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // IDLE reads the top entry for a new pop; RD_A fetches the entry below it for POP2.
  assign rd_ptr = (state == IDLE) ? (count - ONE) : (count - TWO);
  assign wr_en  = (state == IDLE) && cmd_valid && (cmd_op == OP_PUSH) && !full;

  always_ff @(posedge clk) begin
    if (wr_en) mem[count[AW-1:0]] <= cmd_data;
    rd_data <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_error  <= 1'b0;
      rsp_a      <= '0;
      rsp_b      <= '0;
      count      <= '0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      err_q      <= 1'b0;
      pop2_q     <= 1'b0;
`ifdef STACK_PEEK_EN
      peek_q     <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            err_q     <= 1'b0;
            pop2_q    <= 1'b0;
`ifdef STACK_PEEK_EN
            peek_q    <= 1'b0;
`endif
            state     <= RESP;
            case (cmd_op)
              OP_PUSH: begin
                if (!full) count <= count + ONE;
                else begin
                  err_q      <= 1'b1;
                  ovf_sticky <= 1'b1;
                end
              end
              OP_POP: begin
                if (!empty) state <= RD_A;
                else begin
                  err_q      <= 1'b1;
                  unf_sticky <= 1'b1;
                end
              end
              OP_POP2: begin
                // POP2 is atomic: a single entry is left untouched on failure.
                if (count >= TWO) begin
                  state  <= RD_A;
                  pop2_q <= 1'b1;
                end else begin
                  err_q      <= 1'b1;
                  unf_sticky <= 1'b1;
                end
              end
              OP_CLEAR: begin
                count      <= '0;
                ovf_sticky <= 1'b0;
                unf_sticky <= 1'b0;
              end
`ifdef STACK_PEEK_EN
              OP_PEEK: begin
                if (!empty) begin
                  state  <= RD_A;
                  peek_q <= 1'b1;
                end else begin
                  err_q      <= 1'b1;
                  unf_sticky <= 1'b1;
                end
              end
`endif
              default: err_q <= 1'b1;
            endcase
          end
        end
        RD_A: begin
          a_q <= rd_data;
          if (pop2_q) state <= RD_B;
          else begin
`ifdef STACK_PEEK_EN
            if (!peek_q) count <= count - ONE;
`else
            count <= count - ONE;
`endif
            state <= RESP;
          end
        end
        RD_B: begin
          b_q   <= rd_data;
          count <= count - TWO;
          state <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_error <= err_q;
          rsp_a     <= a_q;
          rsp_b     <= b_q;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
